// File: rtl/axil_multi_adder.sv
// AXI4-Lite slave with NUM_CH independent add/subtract/accumulate channels.
// Each channel occupies a 16-byte window: A, B, RESULT, CTRL/STATUS.

module axil_multi_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int MSB   = DATA_WIDTH - 1;
  localparam int XW    = (DATA_WIDTH < 16) ? 16 : DATA_WIDTH;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CHF_W = ADDR_WIDTH - 4;
  localparam logic [CHF_W:0] NUM_CH_V = (CHF_W + 1)'(NUM_CH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // Signed overflow of an addition r = a + b, judged from the sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  w_state_t              w_state_r;
  r_state_t              r_state_r;
  logic                  awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [1:0]            bresp_r, rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  aw_held_r, w_held_r;
  logic [ADDR_WIDTH-1:0] awaddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [SW-1:0]         wstrb_r;

  logic [DATA_WIDTH-1:0] a_r     [NUM_CH];
  logic [DATA_WIDTH-1:0] b_r     [NUM_CH];
  logic [DATA_WIDTH-1:0] res_r   [NUM_CH];
  logic [1:0]            op_r    [NUM_CH];
  logic                  done_r  [NUM_CH];
  logic                  carry_r [NUM_CH];
  logic                  ovf_r   [NUM_CH];

  logic                  cmp_pend_r;
  logic [CH_W-1:0]       cmp_ch_r;
  logic [1:0]            cmp_op_r;

  logic                  aw_hs_s, w_hs_s, aw_have_s, w_have_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [XW-1:0]         wr_data_x_s;
  logic [SW-1:0]         wr_strb_s;
  logic                  wr_ch_ok_s, wr_ctrl_en_s, wr_err_s;
  logic [CH_W-1:0]       wr_ch_s;
  logic [1:0]            wr_reg_s;

  logic [DATA_WIDTH-1:0] opa_s, opb_s, acc_s, cmp_res_s;
  logic [DATA_WIDTH:0]   sum_s;
  logic                  cmp_carry_s, cmp_ovf_s;

  logic                  rd_ok_s;
  logic [CH_W-1:0]       rd_ch_s;
  logic [1:0]            rd_reg_s, rd_resp_s;
  logic [XW-1:0]         rd_ctrl_x_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  unused_s;

  assign s1_axi_awready = awready_r;
  assign s1_axi_wready  = wready_r;
  assign s1_axi_bvalid  = bvalid_r;
  assign s1_axi_bresp   = bresp_r;
  assign s1_axi_arready = arready_r;
  assign s1_axi_rvalid  = rvalid_r;
  assign s1_axi_rresp   = rresp_r;
  assign s1_axi_rdata   = rdata_r;
  assign unused_s = ^{wr_addr_s[1:0], s1_axi_araddr[1:0], wr_data_x_s, rd_ctrl_x_s};

  // Write decode: merge a previously latched AW/W beat with one arriving now.
  always_comb begin
    aw_hs_s      = s1_axi_awvalid & awready_r;
    w_hs_s       = s1_axi_wvalid & wready_r;
    aw_have_s    = aw_held_r | aw_hs_s;
    w_have_s     = w_held_r | w_hs_s;
    wr_addr_s    = aw_held_r ? awaddr_r : s1_axi_awaddr;
    wr_data_s    = w_held_r ? wdata_r : s1_axi_wdata;
    wr_strb_s    = w_held_r ? wstrb_r : s1_axi_wstrb;
    wr_data_x_s  = XW'(wr_data_s);
    wr_ch_ok_s   = ({1'b0, wr_addr_s[ADDR_WIDTH-1:4]} < NUM_CH_V);
    wr_ch_s      = wr_addr_s[CH_W+3:4];
    wr_reg_s     = wr_addr_s[3:2];
    wr_ctrl_en_s = (wr_reg_s == 2'd3) && wr_strb_s[0];
    wr_err_s     = !wr_ch_ok_s || (wr_reg_s == 2'd2) ||
                   (wr_ctrl_en_s && (wr_data_x_s[2:1] == 2'b11));
  end

  // Arithmetic for the pending START, evaluated one cycle after the CTRL write.
  always_comb begin
    opa_s       = a_r[cmp_ch_r];
    opb_s       = b_r[cmp_ch_r];
    acc_s       = res_r[cmp_ch_r];
    sum_s       = '0;
    cmp_res_s   = acc_s;
    cmp_carry_s = 1'b0;
    cmp_ovf_s   = 1'b0;
    case (cmp_op_r)
      OP_ADD: begin
        sum_s       = {1'b0, opa_s} + {1'b0, opb_s};
        cmp_res_s   = sum_s[MSB:0];
        cmp_carry_s = sum_s[DATA_WIDTH];
        cmp_ovf_s   = add_ovf(opa_s[MSB], opb_s[MSB], sum_s[MSB]);
      end
      OP_SUB: begin
        // The borrow appears as bit DATA_WIDTH of the widened difference.
        sum_s       = {1'b0, opa_s} - {1'b0, opb_s};
        cmp_res_s   = sum_s[MSB:0];
        cmp_carry_s = sum_s[DATA_WIDTH];
        cmp_ovf_s   = add_ovf(opa_s[MSB], ~opb_s[MSB], sum_s[MSB]);
      end
      OP_ACC: begin
        sum_s       = {1'b0, acc_s} + {1'b0, opa_s};
        cmp_res_s   = sum_s[MSB:0];
        cmp_carry_s = sum_s[DATA_WIDTH];
        cmp_ovf_s   = add_ovf(acc_s[MSB], opa_s[MSB], sum_s[MSB]);
      end
      default: begin
        cmp_res_s = acc_s;
      end
    endcase
  end

  // Read decode and register mux.
  always_comb begin
    rd_ok_s     = ({1'b0, s1_axi_araddr[ADDR_WIDTH-1:4]} < NUM_CH_V);
    rd_ch_s     = s1_axi_araddr[CH_W+3:4];
    rd_reg_s    = s1_axi_araddr[3:2];
    rd_ctrl_x_s = '0;
    rd_data_s   = '0;
    rd_resp_s   = RESP_OKAY;
    if (!rd_ok_s) begin
      rd_resp_s = RESP_SLVERR;
    end else begin
      rd_ctrl_x_s[2:1] = op_r[rd_ch_s];
      rd_ctrl_x_s[8]   = done_r[rd_ch_s];
      rd_ctrl_x_s[9]   = carry_r[rd_ch_s];
      rd_ctrl_x_s[10]  = ovf_r[rd_ch_s];
      case (rd_reg_s)
        2'd0:    rd_data_s = a_r[rd_ch_s];
        2'd1:    rd_data_s = b_r[rd_ch_s];
        2'd2:    rd_data_s = res_r[rd_ch_s];
        2'd3:    rd_data_s = rd_ctrl_x_s[MSB:0];
        default: rd_data_s = '0;
      endcase
    end
  end

  // Write FSM, channel register file and compute commit.
  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      w_state_r  <= W_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      awaddr_r   <= '0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
      cmp_pend_r <= 1'b0;
      cmp_ch_r   <= '0;
      cmp_op_r   <= 2'b00;
      for (int c = 0; c < NUM_CH; c++) begin
        a_r[c]     <= '0;
        b_r[c]     <= '0;
        res_r[c]   <= '0;
        op_r[c]    <= 2'b00;
        done_r[c]  <= 1'b0;
        carry_r[c] <= 1'b0;
        ovf_r[c]   <= 1'b0;
      end
    end else begin
      if (cmp_pend_r) begin
        res_r[cmp_ch_r]   <= cmp_res_s;
        carry_r[cmp_ch_r] <= cmp_carry_s;
        ovf_r[cmp_ch_r]   <= cmp_ovf_s;
        done_r[cmp_ch_r]  <= 1'b1;
        cmp_pend_r        <= 1'b0;
      end
      case (w_state_r)
        W_IDLE: begin
          if (aw_have_s && w_have_s) begin
            w_state_r <= W_RESP;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
            if (!wr_err_s) begin
              case (wr_reg_s)
                2'd0: begin
                  for (int i = 0; i < SW; i++)
                    if (wr_strb_s[i]) a_r[wr_ch_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
                2'd1: begin
                  for (int i = 0; i < SW; i++)
                    if (wr_strb_s[i]) b_r[wr_ch_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
                2'd3: begin
                  if (wr_ctrl_en_s) begin
                    op_r[wr_ch_s] <= wr_data_x_s[2:1];
                    // START takes precedence over DONE W1C so DONE ends set.
                    if (wr_data_x_s[0]) begin
                      cmp_pend_r <= 1'b1;
                      cmp_ch_r   <= wr_ch_s;
                      cmp_op_r   <= wr_data_x_s[2:1];
                    end else if (wr_data_x_s[8]) begin
                      done_r[wr_ch_s] <= 1'b0;
                    end
                  end
                end
                default: begin
                end
              endcase
            end
          end else begin
            if (aw_hs_s) begin
              aw_held_r <= 1'b1;
              awaddr_r  <= s1_axi_awaddr;
            end
            if (w_hs_s) begin
              w_held_r <= 1'b1;
              wdata_r  <= s1_axi_wdata;
              wstrb_r  <= s1_axi_wstrb;
            end
            awready_r <= !aw_have_s;
            wready_r  <= !w_have_s;
          end
        end
        W_RESP: begin
          if (s1_axi_bready) begin
            w_state_r <= W_IDLE;
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: capture data at AR acceptance and hold it until R handshake.
  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= '0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (s1_axi_arvalid && arready_r) begin
            r_state_r <= R_DATA;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rresp_r   <= rd_resp_s;
            rdata_r   <= rd_data_s;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (s1_axi_rready) begin
            r_state_r <= R_IDLE;
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_multi_adder.sv
// Directed bench for axil_multi_adder; expected responses flow through
// scoreboard queues and are checked when the B/R channel delivers them.

module tb_axil_multi_adder;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  axil_multi_adder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_CH(4)) dut (
    .s1_axi_aclk(clk), .s1_axi_areset(areset),
    .s1_axi_awaddr(awaddr), .s1_axi_awvalid(awvalid), .s1_axi_awready(awready),
    .s1_axi_wdata(wdata), .s1_axi_wstrb(wstrb), .s1_axi_wvalid(wvalid), .s1_axi_wready(wready),
    .s1_axi_bresp(bresp), .s1_axi_bvalid(bvalid), .s1_axi_bready(bready),
    .s1_axi_araddr(araddr), .s1_axi_arvalid(arvalid), .s1_axi_arready(arready),
    .s1_axi_rdata(rdata), .s1_axi_rresp(rresp), .s1_axi_rvalid(rvalid), .s1_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic [1:0] exp_resp, input int w_lag, input int b_lag);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0;
    logic [1:0] exp;
    bq.push_back(exp_resp);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = (w_lag == 0);
    while (!(aw_done && w_done) && cyc < 40) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      step();
      cyc++;
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
      if (w_fire) begin wvalid = 1'b0; w_done = 1; end
      else if (!w_done && cyc >= w_lag) wvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_w_accept", {aw_done, w_done}, 2'b11);
    chk("b_latency", bvalid, 1'b1);
    for (int i = 0; i < b_lag; i++) begin
      step();
      chk("b_hold", {bvalid, bresp}, {1'b1, exp_resp});
    end
    cyc = 0;
    while (!bvalid && cyc < 20) begin step(); cyc++; end
    bready = 1'b1;
    chk("b_queue", bq.size(), 1);
    if (bq.size() > 0) begin
      exp = bq.pop_front();
      chk($sformatf("bresp@%0h", addr), bresp, exp);
    end
    step();
    bready = 1'b0;
    chk("b_drop", bvalid, 1'b0);
  endtask

  task automatic axi_rd(input logic [7:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp, input int r_lag);
    bit fire = 0;
    int cyc = 0;
    logic [33:0] exp;
    rq.push_back({exp_resp, exp_data});
    araddr = addr; arvalid = 1'b1;
    while (!fire && cyc < 40) begin
      fire = arready;
      step();
      cyc++;
    end
    arvalid = 1'b0;
    chk("ar_accept", fire, 1'b1);
    chk("r_latency", rvalid, 1'b1);
    for (int i = 0; i < r_lag; i++) begin
      step();
      chk("r_hold", {rvalid, rresp, rdata}, {1'b1, exp_resp, exp_data});
    end
    cyc = 0;
    while (!rvalid && cyc < 20) begin step(); cyc++; end
    rready = 1'b1;
    chk("r_queue", rq.size(), 1);
    if (rq.size() > 0) begin
      exp = rq.pop_front();
      chk($sformatf("rdata@%0h", addr), rdata, exp[31:0]);
      chk($sformatf("rresp@%0h", addr), rresp, exp[33:32]);
    end
    step();
    rready = 1'b0;
    chk("r_drop", rvalid, 1'b0);
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) step();
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 32'h0);
    areset = 1'b0;
    step();
    chk("readies_up", {awready, wready, arready}, 3'b111);

    axi_rd(8'h00, 32'h0, OKAY, 0);
    axi_rd(8'h08, 32'h0, OKAY, 0);
    axi_rd(8'h0C, 32'h0, OKAY, 0);

    // ch1 ADD with carry out
    axi_wr(8'h10, 32'hFFFF_FFFF, 4'hF, OKAY, 0, 0);
    axi_wr(8'h14, 32'h0000_0001, 4'hF, OKAY, 0, 0);
    axi_wr(8'h1C, 32'h0000_0001, 4'hF, OKAY, 0, 0);
    axi_rd(8'h18, 32'h0, OKAY, 0);
    axi_rd(8'h1C, 32'h300, OKAY, 0);

    // ch2 SUB without and with signed overflow
    axi_wr(8'h20, 32'h7FFF_FFFF, 4'hF, OKAY, 0, 0);
    axi_wr(8'h24, 32'h0000_0001, 4'hF, OKAY, 0, 0);
    axi_wr(8'h2C, 32'h0000_0003, 4'hF, OKAY, 0, 0);
    axi_rd(8'h28, 32'h7FFF_FFFE, OKAY, 0);
    axi_rd(8'h2C, 32'h102, OKAY, 0);
    axi_wr(8'h20, 32'h8000_0000, 4'hF, OKAY, 0, 0);
    axi_wr(8'h2C, 32'h0000_0003, 4'hF, OKAY, 0, 0);
    axi_rd(8'h28, 32'h7FFF_FFFF, OKAY, 0);
    axi_rd(8'h2C, 32'h502, OKAY, 0);

    // ch0 accumulate three times, then clear DONE
    axi_wr(8'h00, 32'h5, 4'hF, OKAY, 0, 0);
    axi_wr(8'h0C, 32'h5, 4'hF, OKAY, 0, 0);
    axi_rd(8'h08, 32'd5, OKAY, 0);
    axi_wr(8'h0C, 32'h5, 4'hF, OKAY, 0, 0);
    axi_rd(8'h08, 32'd10, OKAY, 0);
    axi_wr(8'h0C, 32'h5, 4'hF, OKAY, 0, 0);
    axi_rd(8'h08, 32'd15, OKAY, 0);
    axi_rd(8'h0C, 32'h104, OKAY, 0);
    axi_wr(8'h0C, 32'h100, 4'hF, OKAY, 0, 0);
    axi_rd(8'h0C, 32'h000, OKAY, 0);
    axi_rd(8'h08, 32'd15, OKAY, 0);

    // error paths leave state untouched
    axi_wr(8'h18, 32'h1234, 4'hF, SLVERR, 0, 0);
    axi_rd(8'h18, 32'h0, OKAY, 0);
    axi_wr(8'h1C, 32'h7, 4'hF, SLVERR, 0, 0);
    axi_rd(8'h1C, 32'h300, OKAY, 0);
    axi_wr(8'h1C, 32'h100, 4'h2, OKAY, 0, 0);
    axi_rd(8'h1C, 32'h300, OKAY, 0);
    axi_wr(8'h40, 32'hDEAD, 4'hF, SLVERR, 0, 0);
    axi_rd(8'h00, 32'h5, OKAY, 0);
    axi_rd(8'h40, 32'h0, SLVERR, 0);

    // START with DONE W1C in the same write: DONE ends set
    axi_wr(8'h1C, 32'h100, 4'hF, OKAY, 0, 0);
    axi_rd(8'h1C, 32'h200, OKAY, 0);
    axi_wr(8'h1C, 32'h101, 4'hF, OKAY, 0, 0);
    axi_rd(8'h1C, 32'h300, OKAY, 0);

    // handshake stress on ch3
    axi_wr(8'h30, 32'hAABB_CCDD, 4'hF, OKAY, 3, 5);
    axi_wr(8'h30, 32'h1122_3344, 4'h2, OKAY, 0, 0);
    axi_rd(8'h30, 32'hAABB_33DD, OKAY, 5);
    fork
      axi_wr(8'h34, 32'h1234_5678, 4'hF, OKAY, 1, 2);
      axi_rd(8'h30, 32'hAABB_33DD, OKAY, 3);
    join
    axi_rd(8'h34, 32'h1234_5678, OKAY, 0);

    // reset while a read response is pending
    araddr = 8'h30; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("mid_rvalid", rvalid, 1'b1);
    areset = 1'b1;
    step();
    chk("mid_rst_rvalid", {rvalid, arready}, 2'b00);
    areset = 1'b0;
    step();
    axi_rd(8'h30, 32'h0, OKAY, 0);
    axi_rd(8'h1C, 32'h0, OKAY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axil_multi_adder.md
# axil_multi_adder

AXI4-Lite memory-mapped arithmetic slave; successor to the single-channel adder peripheral. Provides NUM_CH independent channels, each with operand A/B registers, an operation select (add, subtract, accumulate), a registered result, and sticky carry/overflow/done status. It sits on the s1 AXI4-Lite slave port. Write, response and read channels follow full VALID/READY handshake rules with OKAY/SLVERR responses.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result/bus width; multiple of 8, 8..64
- ADDR_WIDTH, 8, byte address width; must satisfy NUM_CH*16 <= 2^ADDR_WIDTH
- NUM_CH, 4, number of channels, 1..16

Ports:
- s1_axi_aclk  in  1  single clock; all logic on rising edge
- s1_axi_areset  in  1  reset, synchronous, active-high
- s1_axi_awaddr  in  ADDR_WIDTH  write address
- s1_axi_awvalid / s1_axi_awready  in / out  1  AW handshake
- s1_axi_wdata  in  DATA_WIDTH  write data
- s1_axi_wstrb  in  DATA_WIDTH/8  byte enables
- s1_axi_wvalid / s1_axi_wready  in / out  1  W handshake
- s1_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s1_axi_bvalid / s1_axi_bready  out / in  1  B handshake
- s1_axi_araddr  in  ADDR_WIDTH  read address
- s1_axi_arvalid / s1_axi_arready  in / out  1  AR handshake
- s1_axi_rdata  out  DATA_WIDTH  read data
- s1_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s1_axi_rvalid / s1_axi_rready  out / in  1  R handshake

## Operation
- Address decode: ch = addr[ADDR_WIDTH-1:4], reg = addr[3:2], addr[1:0] ignored. ch >= NUM_CH -> SLVERR, no effect, rdata 0.
- Per-channel map: 0x0 A (RW), 0x4 B (RW), 0x8 RESULT (RO; write -> SLVERR, no effect), 0xC CTRL/STATUS.
- A, B writes honour wstrb per byte. CTRL updated only when wstrb[0]=1; otherwise OKAY, no effect.
- CTRL write bits: [0] START (self-clearing, reads 0), [2:1] OP (00 ADD, 01 SUB, 10 ACC, 11 reserved -> SLVERR, whole write dropped), [8] DONE W1C.
- CTRL read: [2:1] OP, [8] DONE, [9] CARRY, [10] OVF, others 0.
- Compute on START: ADD R=A+B; SUB R=A-B; ACC R=R+A. R truncated to DATA_WIDTH. CARRY = unsigned carry-out (ADD/ACC) or borrow A<B (SUB). OVF = two's-complement signed overflow. DONE set. CARRY/OVF replaced each compute; OP from same write is used.
- START together with DONE W1C in one write: compute wins, DONE ends 1.
- Write FSM: W_IDLE (awready=wready=1) accepts AW and W independently, latching each; when both held -> W_RESP (awready=wready=0, bvalid=1) until bready -> W_IDLE.
- Read FSM: R_IDLE (arready=1) -> on AR handshake capture rdata/rresp -> R_DATA (arready=0, rvalid=1) until rready -> R_IDLE.
- Read and write FSMs independent; concurrent operation permitted.

## Timing
- Reset (s1_axi_areset=1 at edge): all registers, status, OP = 0; awready, wready, arready, bvalid, rvalid = 0; bresp = rresp = 00; rdata = 0. Readies go to 1 the cycle after reset deasserts.
- Reset mid-transaction aborts it: pending bvalid/rvalid drop; no register update.
- Write: last of AW/W accepted at edge N -> register update and bvalid=1 at N+1; earliest next AW/W acceptance at edge after B handshake. Back-to-back: one write per 2 cycles minimum.
- Compute: START accepted edge N -> RESULT, CARRY, OVF, DONE valid at N+2. No overlap possible, since next write is accepted no earlier than N+2.
- Read: AR accepted edge M -> rvalid, rdata at M+1, held stable until rready. rdata is sampled at M; same-edge write/compute is not reflected.
- bvalid/rvalid never depend combinationally on bready/rready; data/resp stable while valid and not ready.

## Test plan
- Reset then read ch0 0x0, 0x8, 0xC -> rdata 0, OKAY, rvalid 1 cycle after each AR.
- ch1: A=0xFFFF_FFFF, B=0x1, CTRL=0x1 (ADD) -> RESULT 0x0, CTRL read 0x300 (DONE, CARRY), RESULT stable at START+2.
- ch2: A=0x7FFF_FFFF, B=0x1, CTRL=0x3 (SUB), then A=0x8000_0000, CTRL=0x3 -> first 0x7FFF_FFFE OVF=0; second 0x7FFF_FFFF OVF=1, CARRY=0.
- ch0 ACC: A=5, CTRL=0x5 three times -> RESULT 5, 10, 15; write CTRL=0x100 -> DONE clears, RESULT 15 kept.
- Errors: write 0x8, CTRL OP=11, address ch=NUM_CH, read ch=NUM_CH -> bresp/rresp 10, no state change, rdata 0.
- Handshake stress: AW 3 cycles before W, bready/rready held low 5 cycles, concurrent read/write, wstrb=0x2 write to A -> only byte1 changes, bvalid/rdata stable until handshake.
